// File: rtl/fwft_stream_packer.sv
// Packs PACK_RATIO FWFT FIFO entries (little-endian) into one wide valid/ready word with keep/last.
// Optional idle auto-flush is built when PACKER_TIMEOUT_EN is defined.
module fwft_stream_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACK_RATIO  = 4,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int WORD_BITS = DATA_WIDTH * PACK_RATIO;
  localparam int LANE_W    = $clog2(PACK_RATIO);
  localparam int WCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BURST_LEN - 1);

  if (PACK_RATIO < 2 || BURST_LEN < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fwft_stream_packer: illegal parameter value");
  end

  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                  flush_req_q, flush_req_d;
  logic [WORD_BITS-1:0]  acc_q, acc_d;
  logic [WORD_BITS-1:0]  m_data_q, m_data_d;
  logic [PACK_RATIO-1:0] m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;

  logic [WORD_BITS-1:0]  acc_next;
  logic [PACK_RATIO-1:0] part_keep;
  logic                  out_free;
  logic                  last_lane;
  logic                  pop;
  logic                  timeout;
  logic                  flush_set;

  assign out_free   = ~m_valid_q | m_ready;
  assign last_lane  = (lane_cnt_q == LAST_LANE);
  assign pop        = ~fifo_empty & ~flush_req_q & (~last_lane | out_free);
  assign fifo_rd_en = pop;
  assign flush_set  = flush | timeout;

  // acc_next is the accumulator with the FIFO head dropped into the current lane.
  for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
    assign acc_next[gi*DATA_WIDTH +: DATA_WIDTH] =
      (lane_cnt_q == LANE_W'(gi)) ? fifo_dout : acc_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign part_keep[gi] = (LANE_W'(gi) < lane_cnt_q);
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (pop || flush || flush_req_q || lane_cnt_q == '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
      timeout    = 1'b1;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) idle_cnt_q <= '0;
    else           idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    word_cnt_d  = word_cnt_q;
    flush_req_d = flush_req_q;
    acc_d       = acc_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (pop) begin
      if (last_lane) begin
        // A flush arriving with the completing byte just closes the packet on this word.
        m_data_d   = acc_next;
        m_keep_d   = '1;
        m_valid_d  = 1'b1;
        m_last_d   = (word_cnt_q == LAST_WORD) | flush_set;
        word_cnt_d = (flush_set || word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + WCNT_W'(1);
        lane_cnt_d = '0;
        acc_d      = '0;
      end else begin
        lane_cnt_d  = lane_cnt_q + LANE_W'(1);
        acc_d       = acc_next;
        flush_req_d = flush_set;
      end
    end else if (flush_req_q) begin
      if (out_free) begin
        flush_req_d = 1'b0;
        if (lane_cnt_q != '0) begin
          m_data_d   = acc_q;
          m_keep_d   = part_keep;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b1;
          lane_cnt_d = '0;
          word_cnt_d = '0;
          acc_d      = '0;
        end
      end
    end else if (flush_set) begin
      flush_req_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      lane_cnt_q  <= '0;
      word_cnt_q  <= '0;
      flush_req_q <= 1'b0;
      acc_q       <= '0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      word_cnt_q  <= word_cnt_d;
      flush_req_q <= flush_req_d;
      acc_q       <= acc_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_fwft_stream_packer.sv
// Self-checking bench for fwft_stream_packer: vector table, directed sequences, random traffic vs. word-level model.
module tb_fwft_stream_packer;
  logic        clk = 1'b0;
  logic        rd_rst_n, fifo_empty, fifo_rd_en, flush, m_last, m_valid, m_ready;
  logic [7:0]  fifo_dout;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  fwft_stream_packer #(
    .DATA_WIDTH(8), .PACK_RATIO(4), .BURST_LEN(16), .TIMEOUT_CYC(8)
  ) dut (
    .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
  typedef struct {
    logic empty; logic [7:0] dout; logic fl; logic rdy;
    logic rd_en; logic valid; logic [31:0] data; logic [3:0] keep; logic last;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] fq[$];
  logic [7:0] grp[$];
  word_t      exp_q[$];
  word_t      got_q[$];
  int         wc = 0, idle = 0, pops = 0;
  bit         hold_empty = 1'b1;
  bit         last_rd_en, last_valid;
  logic [31:0] last_data;
  bit         prev_live = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  word_t      prev_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: bytes accumulate in grp; a word leaves when 4 bytes are held or a flush closes it.
  task automatic emit_group(input bit force_last);
    word_t w;
    w = '0;
    foreach (grp[i]) begin
      w.data[i*8 +: 8] = grp[i];
      w.keep[i] = 1'b1;
    end
    if (grp.size() == 4) begin
      w.last = force_last || (wc == 15);
      wc = force_last ? 0 : (wc + 1) % 16;
    end else begin
      w.last = 1'b1;
      wc = 0;
    end
    exp_q.push_back(w);
    grp.delete();
  endtask

  task automatic model_cycle(input bit popped, input logic [7:0] b, input bit fl);
    if (popped) grp.push_back(b);
    if (grp.size() == 4) emit_group(fl);
    else if (fl && grp.size() != 0) emit_group(1'b1);
`ifdef PACKER_TIMEOUT_EN
    if (popped || fl) idle = 0;
    else if (grp.size() != 0) begin
      idle++;
      if (idle == 8) begin
        emit_group(1'b1);
        idle = 0;
      end
    end
`endif
  endtask

  task automatic model_reset();
    grp.delete(); exp_q.delete(); got_q.delete();
    wc = 0; idle = 0;
  endtask

  // One clock: drive at edge+1, sample at edge+2, then advance to the next edge+1.
  task automatic run_cycle(input bit fl, input bit rdy);
    bit popped;
    logic [7:0] b;
    word_t cur;
    flush = fl; m_ready = rdy;
    fifo_empty = hold_empty || (fq.size() == 0);
    fifo_dout  = fifo_empty ? 8'h00 : fq[0];
    #1;
    cur = {m_data, m_keep, m_last};
    check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
    if (prev_live && rd_rst_n && prev_valid && !prev_ready)
      check("held_word_stable", {m_valid, cur}, {1'b1, prev_word});
    if (rd_rst_n && m_valid && m_ready) got_q.push_back(cur);
    popped = fifo_rd_en; b = fifo_dout;
    last_rd_en = fifo_rd_en; last_valid = m_valid; last_data = m_data;
    if (!rd_rst_n) model_reset();
    else model_cycle(popped, b, fl);
    prev_live = rd_rst_n; prev_valid = m_valid; prev_ready = rdy; prev_word = cur;
    @(posedge clk); #1;
    if (popped) begin
      b = fq.pop_front();
      pops++;
    end
  endtask

  task automatic do_reset();
    hold_empty = 1'b1; rd_rst_n = 1'b0;
    run_cycle(1'b0, 1'b1); run_cycle(1'b0, 1'b1);
    rd_rst_n = 1'b1; hold_empty = 1'b0; pops = 0;
  endtask

  task automatic compare_lists(input string tag);
    check({tag, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
  endtask

  initial begin
    vec_t vt[19];
    int   vcnt, pop_cyc, first_valid, nlast;

    // empty dout fl rdy | rd_en valid data keep last
    vt[0]  = '{0, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[1]  = '{0, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[2]  = '{0, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[3]  = '{0, 8'h04, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[4]  = '{1, 8'h00, 0, 1, 0, 1, 32'h04030201, 4'hF, 0};
    vt[5]  = '{0, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[6]  = '{0, 8'hBB, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[7]  = '{1, 8'h00, 1, 1, 0, 0, 32'h0, 4'h0, 0};
    vt[8]  = '{0, 8'hCC, 0, 1, 0, 0, 32'h0, 4'h0, 0};
    vt[9]  = '{0, 8'hCC, 0, 1, 1, 1, 32'h0000BBAA, 4'h3, 1};
    vt[10] = '{0, 8'hDD, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[11] = '{0, 8'hEE, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[12] = '{0, 8'hFF, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[13] = '{1, 8'h00, 0, 1, 0, 1, 32'hFFEEDDCC, 4'hF, 0};
    vt[14] = '{1, 8'h00, 1, 1, 0, 0, 32'h0, 4'h0, 0};
    vt[15] = '{0, 8'h11, 0, 1, 0, 0, 32'h0, 4'h0, 0};
    vt[16] = '{0, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0};
    vt[17] = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};
    vt[18] = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};

    rd_rst_n = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00; flush = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_keep", m_keep, 0);
    check("reset_m_last", m_last, 0);
    rd_rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      fifo_empty = vt[i].empty; fifo_dout = vt[i].dout; flush = vt[i].fl; m_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].rd_en);
      check($sformatf("vec%0d_valid", i), m_valid, vt[i].valid);
      if (vt[i].valid)
        check($sformatf("vec%0d_word", i), {m_data, m_keep, m_last}, {vt[i].data, vt[i].keep, vt[i].last});
      @(posedge clk); #1;
    end

    // 64 back-to-back bytes: one pop per cycle, m_last only on word 16
    do_reset();
    for (int i = 0; i < 64; i++) fq.push_back(8'(i));
    vcnt = 0;
    for (int i = 0; i < 64; i++) begin
      run_cycle(1'b0, 1'b1);
      vcnt += int'(last_rd_en);
    end
    check("burst_rd_en_cycles", vcnt, 64);
    repeat (4) run_cycle(1'b0, 1'b1);
    compare_lists("burst_words");
    nlast = 0;
    foreach (got_q[i]) nlast += int'(got_q[i].last);
    check("burst_last_count", nlast, 1);
    if (got_q.size() == 16) check("burst_word16", got_q[15], {32'h3F3E3D3C, 4'hF, 1'b1});

    // Back-pressure: 4 pops fill the output, 3 more fill lanes 0..2, then pops stop
    do_reset();
    for (int i = 0; i < 40; i++) fq.push_back(8'(8'h40 + i));
    repeat (14) run_cycle(1'b0, 1'b0);
    check("stall_pops", pops, 7);
    check("stall_rd_en", last_rd_en, 0);
    check("stall_held_word", {last_valid, last_data}, {1'b1, 32'h43424140});
    repeat (40) run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b1);
    repeat (6) run_cycle(1'b0, 1'b1);
    compare_lists("stall_words");
    check("stall_total_pops", pops, 40);

    // Reset with a held word and lane_cnt=2 discards both
    do_reset();
    for (int i = 0; i < 20; i++) fq.push_back(8'(8'h80 + i));
    repeat (6) run_cycle(1'b0, 1'b0);
    check("midrst_valid_before", {last_valid, last_data}, {1'b1, 32'h83828180});
    hold_empty = 1'b1; rd_rst_n = 1'b0;
    run_cycle(1'b0, 1'b0);
    rd_rst_n = 1'b1; hold_empty = 1'b0;
    run_cycle(1'b0, 1'b1);
    check("midrst_valid_after", last_valid, 0);
    repeat (8) run_cycle(1'b0, 1'b1);
    check("midrst_have_word", got_q.size() != 0, 1);
    if (got_q.size() != 0) check("midrst_first_word", got_q[0], {32'h89888786, 4'hF, 1'b0});
    run_cycle(1'b1, 1'b1);
    repeat (8) run_cycle(1'b0, 1'b1);
    compare_lists("midrst_words");

    // Single byte then idle FIFO
    do_reset();
    fq.push_back(8'h5A);
    pop_cyc = -1; first_valid = -1;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b0, 1'b1);
      if (last_rd_en && pop_cyc < 0) pop_cyc = i;
      if (last_valid && first_valid < 0) first_valid = i;
    end
`ifdef PACKER_TIMEOUT_EN
    check("timeout_latency", first_valid - pop_cyc, 10);
`else
    check("no_auto_flush", first_valid, -1);
    run_cycle(1'b1, 1'b1);
    repeat (3) run_cycle(1'b0, 1'b1);
`endif
    check("single_word_count", got_q.size(), 1);
    if (got_q.size() != 0) check("single_word", got_q[0], {32'h0000005A, 4'h1, 1'b1});
    compare_lists("single_model");

    // Random traffic against the word-level model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0) fq.push_back(8'($urandom));
      hold_empty = ($urandom_range(0, 7) == 0);
      run_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    hold_empty = 1'b0;
    for (int g = 0; g < 1000 && fq.size() != 0; g++) run_cycle(1'b0, 1'b1);
    check("rand_fifo_drained", fq.size(), 0);
    run_cycle(1'b1, 1'b1);
    repeat (10) run_cycle(1'b0, 1'b1);
    compare_lists("rand_words");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fwft_stream_packer.md
Name: fwft_stream_packer

Overview:
- Read-side consumer of the async FIFO running in FWFT mode, placed in the FIFO's read clock domain.
- Pops DATA_WIDTH-bit entries and packs PACK_RATIO of them, little-endian, into one wide word.
- Presents the packed word on a valid/ready master stream with a byte-lane keep mask and a packet-last marker every BURST_LEN words.
- A flush input forces out a partially filled word.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry / one lane.
- PACK_RATIO, 4, lanes per output word (>=2).
- BURST_LEN, 16, output words per packet; m_last marks word BURST_LEN-1 (>=1).
- TIMEOUT_CYC, 8, idle cycles before auto-flush; used only with PACKER_TIMEOUT_EN.

Ports:
- rd_clk  in  1  clock, shared with the FIFO read side.
- rd_rst_n  in  1  synchronous active-low reset.
- fifo_dout  in  DATA_WIDTH  FWFT head data, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe (combinational).
- flush  in  1  single-cycle request to emit the partial word.
- m_data  out  DATA_WIDTH*PACK_RATIO  packed word; lane 0 = LSBs.
- m_keep  out  PACK_RATIO  per-lane valid mask.
- m_last  out  1  last word of a packet.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (rd_rst_n=0 at a rd_clk edge):
  - m_valid, m_last, m_data and m_keep go to 0.
  - Internal state clears: lane_cnt=0, word_cnt=0, flush_req=0, accumulator=0.
  - A partial word or a held output word is discarded.
  - Reset asserted mid-operation takes effect at the next edge, with no drain.
- Internal state:
  - lane_cnt counts 0..PACK_RATIO-1.
  - word_cnt counts 0..BURST_LEN-1 and wraps to 0.
  - out_free = ~m_valid | m_ready.
- Pop rule: fifo_rd_en = ~fifo_empty & ~flush_req & (lane_cnt!=PACK_RATIO-1 | out_free).
  - fifo_rd_en is never asserted while fifo_empty=1.
  - A pop consumes fifo_dout in the same cycle.
- Normal pop: fifo_dout is written to lane[lane_cnt] and lane_cnt increments.
- Pop of the last lane:
  - The next edge loads the full word into m_data, with m_keep all ones, m_valid=1 and m_last=(word_cnt==BURST_LEN-1).
  - lane_cnt goes to 0, word_cnt increments or wraps, and the accumulator clears.
  - Latency: m_valid rises 1 cycle after the pop of the final lane.
- Throughput: 1 pop per cycle sustained with m_ready=1, giving 1 word every PACK_RATIO cycles with no bubble.
- Stream rule:
  - While m_valid=1 & m_ready=0, m_data, m_keep and m_last hold stable.
  - m_valid drops after the handshake unless a new word loads in the same edge.
- Flush:
  - A flush pulse sets flush_req. A pop in the pulse cycle is still taken, and its byte belongs to the flushed word.
  - If that pop completes the word: emit it normally but force m_last=1, set word_cnt=0 and clear flush_req.
  - While flush_req=1, fifo_rd_en is blocked. At the first cycle with out_free:
    - lane_cnt>0: emit the accumulator, unused lanes 0, m_keep=(1<<lane_cnt)-1, m_last=1. Set lane_cnt=0, word_cnt=0, clear flush_req.
    - lane_cnt==0: clear flush_req with no word emitted (no empty words).
  - A flush while flush_req is already set is absorbed.
- State summary:
  - FILL: lane_cnt<PACK_RATIO-1.
  - WAIT_OUT: last lane pending and the output register is held.
  - FLUSH: flush_req=1.

Optional Feature:
- Macro PACKER_TIMEOUT_EN.
- Defined: an idle counter tracks cycles with lane_cnt>0 and no pop.
  - It resets on any pop or flush.
  - Reaching TIMEOUT_CYC sets flush_req exactly as the flush input would.
- Undefined: no counter is built, TIMEOUT_CYC is ignored, and partial words leave only via flush.

Test Plan:
1. Reset; FIFO supplies 0x01..0x04; m_ready=1 -> 1 cycle after the 4th pop: m_data=0x04030201, m_keep=4'hF, m_last=0, m_valid for 1 cycle.
2. 64 continuous bytes 0x00..0x3F, m_ready=1 -> 16 words; m_last=1 only on word 16 (0x3F3E3D3C); fifo_rd_en high on all 64 cycles.
3. m_ready=0 for 10 cycles with the FIFO non-empty -> exactly 3 further pops, then fifo_rd_en=0; m_data held; after m_ready=1, output resumes with no lost or duplicated byte.
4. Pop 0xAA, 0xBB, then pulse flush -> m_data=0x0000BBAA, m_keep=4'b0011, m_last=1; the following 4 bytes form word_cnt=0 with m_last=0.
5. Flush with lane_cnt=0 -> no m_valid. Reset asserted with m_valid=1 and lane_cnt=2 -> m_valid=0 next cycle; the next 4 pops form a fresh word.
6. PACKER_TIMEOUT_EN, TIMEOUT_CYC=8: pop 1 byte 0x5A, then FIFO empty -> after 8 idle cycles, m_data=0x0000005A, m_keep=4'b0001, m_last=1.
